// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: widths, opcodes,
// FSM state encoding and the latched instruction payload.
package regfile_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [OP_W-1:0] OP_LDI = 3'd6;
  localparam logic [OP_W-1:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the register-file sequencer.
// Ports:
//   i_op       opcode (OP_ADD..OP_MOV)
//   i_a, i_b   operands captured from the register file read buses
//   i_imm      immediate (LDI only)
//   o_result_c 8-bit result, modulo 256
//   o_carry_c  carry (ADD), borrow (SUB), last bit shifted out (SHL), else 0
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result_c,
  output logic              o_carry_c
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [DATA_W:0] w_shl;

  // Ninth bit carries out of ADD, borrows for SUB (A < B), and holds the
  // last bit shifted out for SHL (zero for a shift of 0).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_shl  = {1'b0, i_a} << i_b[2:0];

  always_comb begin
    o_result_c = '0;
    o_carry_c  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result_c = w_sum[DATA_W-1:0];
        o_carry_c  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result_c = w_diff[DATA_W-1:0];
        o_carry_c  = w_diff[DATA_W];
      end
      OP_AND: o_result_c = i_a & i_b;
      OP_OR:  o_result_c = i_a | i_b;
      OP_XOR: o_result_c = i_a ^ i_b;
      OP_SHL: begin
        o_result_c = w_shl[DATA_W-1:0];
        o_carry_c  = w_shl[DATA_W];
      end
      OP_LDI: o_result_c = i_imm;
      OP_MOV: o_result_c = i_a;
      default: begin
        o_result_c = '0;
        o_carry_c  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator-side controller for an 8x8 register file (r0 reads as zero).
// Accepts one instruction per valid/ready handshake, reads two sources,
// executes in regfile_seq_alu and writes the result back: READ, EXEC,
// WRITE, then back to IDLE (one instruction every 4 cycles).
// Ports:
//   Clk, Rst_n             clock, async active-low reset
//   instr_valid/ready      instruction handshake (ready only in IDLE)
//   instr_op/rd/rs/rt/imm  instruction fields, latched on accept
//   RX, RY / busX, busY    register file read addresses / read data
//   WEN, RW, busW          register file write port (WEN only in WRITE)
//   done                   one-cycle pulse in the write-back cycle
//   flag_z, flag_c         zero / carry flags
// Build option: define REGFILE_SEQ_FLAGS_EN to include flag_z/flag_c.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic              done
`ifdef REGFILE_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_wen_nxt;
  logic              w_done_nxt;
  logic              w_ready_nxt;

  instr_t            r_instr;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_busw;
  logic              r_wen;
  logic              r_done;
  logic              r_ready;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus next values of the registered control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wen_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_valid && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: w_state_nxt = EXEC;
      EXEC: begin
        w_state_nxt = WRITE;
        w_wen_nxt   = 1'b1;
        w_done_nxt  = 1'b1;
      end
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  // Instruction latch, operand capture and write-port registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_instr <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_rw    <= '0;
      r_busw  <= '0;
      r_wen   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_wen   <= w_wen_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
      if (w_accept) begin
        r_instr <= '{op: instr_op, rd: instr_rd, rs: instr_rs,
                     rt: instr_rt, imm: instr_imm};
      end
      if (r_state == READ) begin
        r_opa <= busX;
        r_opb <= busY;
      end
      // RW/busW only change on entry to WRITE so they hold otherwise
      if (r_state == EXEC) begin
        r_rw   <= r_instr.rd;
        r_busw <= w_alu_result;
      end
    end
  end

  regfile_seq_alu u_alu (
    .i_op       (r_instr.op),
    .i_a        (r_opa),
    .i_b        (r_opb),
    .i_imm      (r_instr.imm),
    .o_result_c (w_alu_result),
    .o_carry_c  (w_alu_carry)
  );

`ifdef REGFILE_SEQ_FLAGS_EN
  logic r_flag_z;
  logic r_flag_c;

  // Flags follow every op except LDI/MOV, which leave them untouched
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if ((r_state == EXEC) && (r_instr.op != OP_LDI) &&
                 (r_instr.op != OP_MOV)) begin
      r_flag_z <= (w_alu_result == '0);
      r_flag_c <= w_alu_carry;
    end
  end

  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
`else
  logic w_carry_unused;
  assign w_carry_unused = w_alu_carry;
`endif

  // Latched read addresses drive the read ports directly
  assign RX          = r_instr.rs;
  assign RY          = r_instr.rt;
  assign instr_ready = r_ready;
  assign WEN         = r_wen;
  assign RW          = r_rw;
  assign busW        = r_busw;
  assign done        = r_done;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer with a behavioural
// 8x8 register file (r0 reads zero, synchronous write).
module tb_regfile_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [2:0] instr_rd = 3'd0;
  logic [2:0] instr_rs = 3'd0;
  logic [2:0] instr_rt = 3'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [2:0] RX, RY, RW;
  logic [7:0] busX, busY, busW;
  logic       WEN, done;
`ifdef REGFILE_SEQ_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  logic [7:0] rf [8] = '{default: 8'h00};
  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] hold_rd  [3] = '{3'd3, 3'd4, 3'd5};
  logic [7:0] hold_res [3] = '{8'hA1, 8'h5A, 8'hFB};

  regfile_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .WEN(WEN), .RW(RW), .busW(busW), .done(done)
`ifdef REGFILE_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  always #5 Clk = ~Clk;

  assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];
  always @(posedge Clk) if (WEN && RW != 3'd0) rf[RW] <= busW;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c, input bit check_c);
`ifdef REGFILE_SEQ_FLAGS_EN
    chk({tag, "/flag_z"}, 8'(flag_z), 8'(z));
    if (check_c) chk({tag, "/flag_c"}, 8'(flag_c), 8'(c));
`endif
  endtask

  // Issue one instruction from IDLE and check every cycle up to write-back.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt,
                           input logic [7:0] imm, input logic [7:0] exp_res);
    int guard = 0;
    while (instr_ready !== 1'b1 && guard < 16) begin
      @(posedge Clk); @(negedge Clk); guard++;
    end
    chk({tag, "/ready_idle"}, 8'(instr_ready), 8'd1);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    instr_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rd = 3'($urandom);
    instr_rs = 3'($urandom); instr_rt = 3'($urandom); instr_imm = 8'($urandom);
    chk({tag, "/rx"}, 8'(RX), 8'(rs));
    chk({tag, "/ry"}, 8'(RY), 8'(rt));
    chk({tag, "/ready_read"}, 8'(instr_ready), 8'd0);
    chk({tag, "/done_read"}, 8'(done), 8'd0);
    @(posedge Clk); @(negedge Clk);
    chk({tag, "/done_exec"}, 8'(done), 8'd0);
    chk({tag, "/wen_exec"}, 8'(WEN), 8'd0);
    @(posedge Clk); @(negedge Clk);
    chk({tag, "/done_wr"}, 8'(done), 8'd1);
    chk({tag, "/wen_wr"}, 8'(WEN), 8'd1);
    chk({tag, "/rw"}, 8'(RW), 8'(rd));
    chk({tag, "/busw"}, busW, exp_res);
    @(posedge Clk); @(negedge Clk);
    chk({tag, "/done_after"}, 8'(done), 8'd0);
    chk({tag, "/wen_after"}, 8'(WEN), 8'd0);
    chk({tag, "/ready_after"}, 8'(instr_ready), 8'd1);
    chk({tag, "/rf"}, rf[rd], (rd == 3'd0) ? 8'h00 : exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst/ready", 8'(instr_ready), 8'd1);
    chk("rst/wen", 8'(WEN), 8'd0);
    chk("rst/done", 8'(done), 8'd0);
    chk("rst/rx", 8'(RX), 8'd0);
    chk("rst/ry", 8'(RY), 8'd0);
    chk("rst/rw", 8'(RW), 8'd0);
    chk("rst/busw", busW, 8'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b1);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Reset asserted during WRITE: no write, instruction lost
    instr_op = 3'd6; instr_rd = 3'd2; instr_rs = 3'd0; instr_rt = 3'd0; instr_imm = 8'h55;
    instr_valid = 1'b1;
    @(posedge Clk); @(negedge Clk);
    instr_valid = 1'b0;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    chk("midrst/wen_before", 8'(WEN), 8'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst/wen_dropped", 8'(WEN), 8'd0);
    chk("midrst/done_dropped", 8'(done), 8'd0);
    @(posedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("midrst/rf2", rf[2], 8'h00);
    chk("midrst/ready", 8'(instr_ready), 8'd1);

    // Arithmetic and flags
    run_instr("ldi_r1", 3'd6, 3'd1, 3'd0, 3'd0, 8'h3C, 8'h3C);
    run_instr("ldi_r2", 3'd6, 3'd2, 3'd0, 3'd0, 8'hC5, 8'hC5);
    run_instr("add_r3", 3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h01);
    chk_flags("add_r3", 1'b0, 1'b1, 1'b1);
    run_instr("sub_r4", 3'd1, 3'd4, 3'd1, 3'd2, 8'h00, 8'h77);
    chk_flags("sub_r4", 1'b0, 1'b1, 1'b1);
    run_instr("sub_r5", 3'd1, 3'd5, 3'd2, 3'd2, 8'h00, 8'h00);
    chk_flags("sub_r5", 1'b1, 1'b0, 1'b1);

    // r0 writes are discarded; LDI/MOV keep flags
    run_instr("ldi_r0", 3'd6, 3'd0, 3'd0, 3'd0, 8'hFF, 8'hFF);
    run_instr("mov_r6", 3'd7, 3'd6, 3'd0, 3'd0, 8'h99, 8'h00);
    run_instr("ldi_r7", 3'd6, 3'd7, 3'd0, 3'd0, 8'h03, 8'h03);
    chk_flags("ldi_keep", 1'b1, 1'b0, 1'b1);

    // Shifts and a dependent back-to-back instruction
    run_instr("shl_r1", 3'd5, 3'd1, 3'd1, 3'd7, 8'h00, 8'hE0);
    chk_flags("shl_r1", 1'b0, 1'b1, 1'b1);
    run_instr("add_dep", 3'd0, 3'd2, 3'd1, 3'd1, 8'h00, 8'hC0);
    chk_flags("add_dep", 1'b0, 1'b1, 1'b1);
    run_instr("shl_zero", 3'd5, 3'd3, 3'd1, 3'd0, 8'h00, 8'hE0);
    chk_flags("shl_zero", 1'b0, 1'b0, 1'b1);
    run_instr("and_r7", 3'd2, 3'd7, 3'd5, 3'd1, 8'h00, 8'h00);
    chk_flags("and_r7", 1'b1, 1'b0, 1'b0);
    run_instr("or_r6", 3'd3, 3'd6, 3'd1, 3'd4, 8'h00, 8'hF7);
    chk_flags("or_r6", 1'b0, 1'b0, 1'b0);

    // Valid held high with fields changing every cycle
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("hold%0d/ready", i), 8'(instr_ready), (i % 4 == 0) ? 8'd1 : 8'd0);
      if (i % 4 == 3) begin
        chk($sformatf("hold%0d/done", i), 8'(done), 8'd1);
        chk($sformatf("hold%0d/rw", i), 8'(RW), 8'(hold_rd[i / 4]));
        chk($sformatf("hold%0d/busw", i), busW, hold_res[i / 4]);
      end else begin
        chk($sformatf("hold%0d/done", i), 8'(done), 8'd0);
      end
      if (i == 0) begin
        instr_op = 3'd6; instr_rd = 3'd3; instr_rs = 3'd0; instr_rt = 3'd0; instr_imm = 8'hA1;
      end else if (i == 4) begin
        instr_op = 3'd6; instr_rd = 3'd4; instr_rs = 3'd0; instr_rt = 3'd0; instr_imm = 8'h5A;
      end else if (i == 8) begin
        instr_op = 3'd4; instr_rd = 3'd5; instr_rs = 3'd3; instr_rt = 3'd4; instr_imm = 8'h00;
      end else begin
        instr_op = 3'd6; instr_rd = 3'd6; instr_rs = 3'(i); instr_rt = 3'(i + 1); instr_imm = 8'hEE;
      end
      instr_valid = 1'b1;
      @(posedge Clk); @(negedge Clk);
    end
    instr_valid = 1'b0;
    chk("hold/ready_end", 8'(instr_ready), 8'd1);
    chk("hold/rf3", rf[3], 8'hA1);
    chk("hold/rf4", rf[4], 8'h5A);
    chk("hold/rf5", rf[5], 8'hFB);
    chk("hold/rf6", rf[6], 8'hF7);
    chk_flags("hold_xor", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
